// File: rtl/fifo_delay_drain.sv
// fifo_delay_drain: pops FIFO words one at a time, holds each for delay_cfg cycles,
// then presents it on a valid/ready port.
module fifo_delay_drain #(
   parameter int DATA_WIDTH = 4,
   parameter int DELAY_W    = 8,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   input  logic [DELAY_W-1:0]    delay_cfg,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  busy,
   output logic [CNT_W-1:0]      drained_count
);
   typedef enum logic [2:0] {IDLE, READ, CAPTURE, WAIT, PRESENT} state_t;
   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic [DELAY_W-1:0]    cnt_q, cnt_d;
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE:    state_d = fifo_empty ? IDLE : READ;
         READ:    state_d = CAPTURE;
         CAPTURE: begin
            hold_d  = fifo_data;
            cnt_d   = delay_cfg;
            state_d = (delay_cfg == '0) ? PRESENT : WAIT;
         end
         WAIT: begin
            cnt_d   = cnt_q - 1'b1;
            state_d = (cnt_q == DELAY_W'(1)) ? PRESENT : WAIT;
         end
         PRESENT: state_d = !out_ready ? PRESENT : fifo_empty ? IDLE : READ;
         default: state_d = IDLE;
      endcase
   end
   // Outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         hold_q        <= '0;
         cnt_q         <= '0;
         fifo_rd_en    <= 1'b0;
         out_valid     <= 1'b0;
         out_data      <= '0;
         busy          <= 1'b0;
         drained_count <= '0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         cnt_q      <= cnt_d;
         fifo_rd_en <= state_d == READ;
         out_valid  <= state_d == PRESENT;
         out_data   <= (state_d == PRESENT) ? hold_d : '0;
         busy       <= state_d != IDLE;
         if (out_valid && out_ready) drained_count <= drained_count + 1'b1;
      end
   end
endmodule

// File: tb/tb_fifo_delay_drain.sv
// tb_fifo_delay_drain: checks fifo_delay_drain against a FIFO model and a
// word-order/timing reference computed from the delay arithmetic.
module tb_fifo_delay_drain;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       fifo_empty;
   logic       fifo_rd_en;
   logic [3:0] fifo_data = '0;
   logic [7:0] delay_cfg = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] out_data;
   logic       busy;
   logic [3:0] drained_count;
   int pass = 0;
   int total = 0;
   fifo_delay_drain #(.DATA_WIDTH(4), .DELAY_W(8), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
      .fifo_data(fifo_data), .delay_cfg(delay_cfg), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .busy(busy),
      .drained_count(drained_count)
   );
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   // FIFO with one-cycle registered read latency
   logic [3:0] mem [0:255];
   int wp = 0;
   int rp = 0;
   assign fifo_empty = (wp == rp);
   always @(posedge clk) if (fifo_rd_en) begin
      fifo_data <= mem[rp];
      rp <= rp + 1;
   end
   int rd_pulses = 0;
   int valid_cycles = 0;
   logic [3:0] hs_data [$];
   logic [3:0] hs_cnt [$];
   int hs_cyc [$];
   always @(negedge clk) if (!rst) begin
      if (fifo_rd_en) rd_pulses++;
      if (out_valid) valid_cycles++;
      if (out_valid && out_ready) begin
         hs_data.push_back(out_data);
         hs_cnt.push_back(drained_count);
         hs_cyc.push_back(cyc);
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic push(input logic [3:0] d);
      mem[wp] = d;
      wp++;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask
   task automatic wait_hs(input int target, input int budget);
      for (int i = 0; i < budget && hs_data.size() < target; i++) tick();
   endtask
   task automatic test_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      total++; if ({fifo_rd_en, out_valid, busy} !== 3'b000) $display("FAIL reset_ctrl got %b exp 000", {fifo_rd_en, out_valid, busy}); else pass++;
      total++; if (out_data !== 4'h0) $display("FAIL reset_data got %h exp 0", out_data); else pass++;
      total++; if (drained_count !== 4'h0) $display("FAIL reset_count got %0d exp 0", drained_count); else pass++;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         total++; if ({fifo_rd_en, out_valid, busy, drained_count} !== 7'b0) $display("FAIL idle_quiet cyc %0d got %b exp 0", i, {fifo_rd_en, out_valid, busy, drained_count}); else pass++;
      end
   endtask
   task automatic test_single();
      int b0, r0, v0, t0;
      do_reset();
      out_ready = 1'b1;
      delay_cfg = 8'd0;
      b0 = hs_data.size(); r0 = rd_pulses; v0 = valid_cycles; t0 = cyc;
      push(4'hA);
      wait_hs(b0 + 1, 20);
      total++; if (hs_data.size() !== b0 + 1) $display("FAIL single_timeout got %0d exp %0d", hs_data.size(), b0 + 1); else pass++;
      total++; if (hs_data[b0] !== 4'hA) $display("FAIL single_data got %h exp a", hs_data[b0]); else pass++;
      total++; if (hs_cyc[b0] !== t0 + 3) $display("FAIL single_latency got %0d exp %0d", hs_cyc[b0] - t0, 3); else pass++;
      tick(); tick(); tick();
      total++; if (rd_pulses - r0 !== 1) $display("FAIL single_rd got %0d exp 1", rd_pulses - r0); else pass++;
      total++; if (valid_cycles - v0 !== 1) $display("FAIL single_valid got %0d exp 1", valid_cycles - v0); else pass++;
      total++; if (drained_count !== 4'd1) $display("FAIL single_count got %0d exp 1", drained_count); else pass++;
      total++; if (busy !== 1'b0) $display("FAIL single_idle got %b exp 0", busy); else pass++;
   endtask
   task automatic test_pacing();
      int b0, r0, t0;
      logic [3:0] exp_q [$];
      do_reset();
      out_ready = 1'b1;
      delay_cfg = 8'd5;
      b0 = hs_data.size(); r0 = rd_pulses; t0 = cyc;
      exp_q = '{4'h1, 4'h2, 4'h3};
      foreach (exp_q[i]) push(exp_q[i]);
      wait_hs(b0 + 3, 100);
      total++; if (hs_data.size() !== b0 + 3) $display("FAIL pace_timeout got %0d exp %0d", hs_data.size(), b0 + 3); else pass++;
      total++; if (hs_cyc[b0] !== t0 + 8) $display("FAIL pace_first got %0d exp 8", hs_cyc[b0] - t0); else pass++;
      for (int i = 0; i < 3; i++) begin
         total++; if (hs_data[b0 + i] !== exp_q[i]) $display("FAIL pace_data[%0d] got %h exp %h", i, hs_data[b0 + i], exp_q[i]); else pass++;
         if (i > 0) begin
            total++; if (hs_cyc[b0 + i] - hs_cyc[b0 + i - 1] !== 8) $display("FAIL pace_gap[%0d] got %0d exp 8", i, hs_cyc[b0 + i] - hs_cyc[b0 + i - 1]); else pass++;
         end
      end
      tick(); tick();
      total++; if (rd_pulses - r0 !== 3) $display("FAIL pace_rd got %0d exp 3", rd_pulses - r0); else pass++;
   endtask
   task automatic test_backpressure();
      int r0;
      do_reset();
      out_ready = 1'b0;
      delay_cfg = 8'd2;
      r0 = rd_pulses;
      push(4'hC);
      for (int i = 0; i < 20 && !out_valid; i++) tick();
      total++; if (out_valid !== 1'b1) $display("FAIL bp_valid_timeout got %b exp 1", out_valid); else pass++;
      for (int i = 0; i < 10; i++) begin
         total++; if ({out_valid, out_data} !== 5'h1C) $display("FAIL bp_hold[%0d] got %h exp 1c", i, {out_valid, out_data}); else pass++;
         tick();
      end
      out_ready = 1'b1;
      total++; if ({out_valid, out_data} !== 5'h1C) $display("FAIL bp_final got %h exp 1c", {out_valid, out_data}); else pass++;
      tick();
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) $display("FAIL bp_drop got %b exp 0", out_valid); else pass++;
      total++; if (drained_count !== 4'd1) $display("FAIL bp_count got %0d exp 1", drained_count); else pass++;
      total++; if (rd_pulses - r0 !== 1) $display("FAIL bp_rd got %0d exp 1", rd_pulses - r0); else pass++;
   endtask
   task automatic test_reset_mid_wait();
      int b0;
      do_reset();
      out_ready = 1'b1;
      delay_cfg = 8'd200;
      push(4'h9);
      for (int i = 0; i < 10; i++) tick();
      total++; if ({busy, out_valid} !== 2'b10) $display("FAIL mid_wait_state got %b exp 10", {busy, out_valid}); else pass++;
      rst = 1'b1;
      #1;
      total++; if ({fifo_rd_en, out_valid, busy, out_data, drained_count} !== 11'b0) $display("FAIL mid_reset got %h exp 0", {fifo_rd_en, out_valid, busy, out_data, drained_count}); else pass++;
      tick();
      rst = 1'b0;
      delay_cfg = 8'd0;
      b0 = hs_data.size();
      push(4'h5);
      wait_hs(b0 + 1, 20);
      tick(); tick();
      total++; if (hs_data.size() !== b0 + 1) $display("FAIL mid_hs_count got %0d exp %0d", hs_data.size(), b0 + 1); else pass++;
      total++; if (hs_data[b0] !== 4'h5) $display("FAIL mid_data got %h exp 5", hs_data[b0]); else pass++;
      total++; if (drained_count !== 4'd1) $display("FAIL mid_count got %0d exp 1", drained_count); else pass++;
   endtask
   task automatic test_wrap();
      int b0;
      do_reset();
      out_ready = 1'b1;
      delay_cfg = 8'd0;
      b0 = hs_data.size();
      for (int i = 0; i < 17; i++) push(4'(i));
      wait_hs(b0 + 17, 100);
      tick();
      total++; if (hs_data.size() !== b0 + 17) $display("FAIL wrap_timeout got %0d exp %0d", hs_data.size(), b0 + 17); else pass++;
      total++; if (hs_cnt[b0 + 15] !== 4'd15) $display("FAIL wrap_pre got %0d exp 15", hs_cnt[b0 + 15]); else pass++;
      total++; if (hs_cnt[b0 + 16] !== 4'd0) $display("FAIL wrap_zero got %0d exp 0", hs_cnt[b0 + 16]); else pass++;
      total++; if (drained_count !== 4'd1) $display("FAIL wrap_final got %0d exp 1", drained_count); else pass++;
      total++; if (hs_data[b0 + 16] !== 4'h0) $display("FAIL wrap_data got %h exp 0", hs_data[b0 + 16]); else pass++;
   endtask
   task automatic test_back_to_back();
      int b0, r0, t0, d, n;
      logic [3:0] exp_q [$];
      do_reset();
      out_ready = 1'b1;
      d = $urandom_range(0, 9);
      n = 8;
      delay_cfg = 8'(d);
      b0 = hs_data.size(); r0 = rd_pulses; t0 = cyc;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(4'($urandom));
         push(exp_q[i]);
      end
      wait_hs(b0 + n, n * (3 + d) + 20);
      tick(); tick();
      total++; if (hs_data.size() !== b0 + n) $display("FAIL b2b_timeout got %0d exp %0d", hs_data.size(), b0 + n); else pass++;
      total++; if (hs_cyc[b0] !== t0 + 3 + d) $display("FAIL b2b_first got %0d exp %0d", hs_cyc[b0] - t0, 3 + d); else pass++;
      for (int i = 0; i < n; i++) begin
         total++; if (hs_data[b0 + i] !== exp_q[i]) $display("FAIL b2b_data[%0d] got %h exp %h", i, hs_data[b0 + i], exp_q[i]); else pass++;
         if (i > 0) begin
            total++; if (hs_cyc[b0 + i] - hs_cyc[b0 + i - 1] !== 3 + d) $display("FAIL b2b_gap[%0d] got %0d exp %0d", i, hs_cyc[b0 + i] - hs_cyc[b0 + i - 1], 3 + d); else pass++;
         end
      end
      total++; if (rd_pulses - r0 !== n) $display("FAIL b2b_rd got %0d exp %0d", rd_pulses - r0, n); else pass++;
      total++; if (drained_count !== 4'(n)) $display("FAIL b2b_count got %0d exp %0d", drained_count, n); else pass++;
   endtask
   task automatic test_random_ready();
      int b0, r0, n;
      logic [3:0] exp_q [$];
      do_reset();
      delay_cfg = 8'($urandom_range(0, 3));
      n = 10;
      b0 = hs_data.size(); r0 = rd_pulses;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(4'($urandom));
         push(exp_q[i]);
      end
      for (int i = 0; i < 600 && hs_data.size() < b0 + n; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         tick();
      end
      out_ready = 1'b0;
      tick(); tick();
      total++; if (hs_data.size() !== b0 + n) $display("FAIL rnd_timeout got %0d exp %0d", hs_data.size(), b0 + n); else pass++;
      for (int i = 0; i < n; i++) begin
         total++; if (hs_data[b0 + i] !== exp_q[i]) $display("FAIL rnd_data[%0d] got %h exp %h", i, hs_data[b0 + i], exp_q[i]); else pass++;
      end
      total++; if (rd_pulses - r0 !== n) $display("FAIL rnd_rd got %0d exp %0d", rd_pulses - r0, n); else pass++;
      total++; if (drained_count !== 4'(n)) $display("FAIL rnd_count got %0d exp %0d", drained_count, n); else pass++;
      total++; if (busy !== 1'b0) $display("FAIL rnd_idle got %b exp 0", busy); else pass++;
   endtask
   initial begin
      test_reset();
      test_single();
      test_pacing();
      test_backpressure();
      test_reset_mid_wait();
      test_wrap();
      test_back_to_back();
      test_random_ready();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
